urp_pcie_tx_replay_ctrl: RTL and testbench
==========================================

# urp_pcie_tx_replay_ctrl

Sequencing controller for the PCIe TX data link layer retry path. It assigns sequence numbers to new TLPs and drives write and read addresses for the external retry buffer. It processes incoming ACK/NAK DLLPs and runs the replay timer and REPLAY_NUM counter. On a NAK or a timeout it shares the single link output between new TLPs and replayed TLPs. It sits between the LCRC generator/retry buffer datapath and the link output register.

## Interface
- SEQ_W, 12, sequence number width (modulo 2^SEQ_W)
- BUF_LG2, 4, log2 of retry buffer depth (max outstanding TLPs = 2^BUF_LG2)
- REPLAY_TIMEOUT, 1024, replay timer expiry in cycles
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- new_valid_i  in  1  new TLP (post-LCRC) available
- new_ready_o  out  1  new TLP accepted this cycle when new_valid_i=1
- seq_o  out  SEQ_W  sequence number of the TLP accepted this cycle (= NEXT_SEQ)
- rb_wren_o  out  1  retry buffer write strobe (= new_valid_i & new_ready_o)
- rb_waddr_o  out  BUF_LG2  write address = NEXT_SEQ[BUF_LG2-1:0]
- rb_rden_o  out  1  retry buffer read strobe; data valid on the next cycle
- rb_raddr_o  out  BUF_LG2  read address = replay pointer low bits
- link_valid_o  out  1  link output valid
- link_sel_o  out  1  0 = new TLP path, 1 = retry buffer read data
- link_ready_i  in  1  link accepts output
- dllp_valid_i  in  1  DLLP strobe
- dllp_i  in  32  [31:24] type (0x00 ACK, 0x10 NAK), [SEQ_W-1:0] AckNak_Seq
- replay_active_o  out  1  replay in progress
- retrain_o  out  1  one-cycle pulse on REPLAY_NUM rollover
- dllp_err_o  out  1  one-cycle pulse for an ACK/NAK seq outside the outstanding window
- outstanding_o  out  BUF_LG2+1  count of unacknowledged TLPs

## Operation
- Registers: NEXT_SEQ (reset 0), ACKD_SEQ (reset 2^SEQ_W-1), replay_ptr, timer, replay_num (2-bit), state. All arithmetic is modulo 2^SEQ_W.
- outstanding = NEXT_SEQ - ACKD_SEQ - 1. Full when outstanding = 2^BUF_LG2.
- States:
  - NORMAL: new_ready_o = !full & link_ready_i. link_valid_o = new_valid_i & new_ready_o. link_sel_o = 0. An accept increments NEXT_SEQ.
  - REPLAY_RD: rb_rden_o = 1, rb_raddr_o = replay_ptr. Always goes to REPLAY_TX next.
  - REPLAY_TX: link_valid_o = 1, link_sel_o = 1, held until link_ready_i.
    - On accept with replay_ptr = NEXT_SEQ-1: go to NORMAL and restart the timer.
    - Otherwise: replay_ptr+1, go to REPLAY_RD.
- new_ready_o = 0 in both replay states.
- ACK/NAK seq s is valid when (NEXT_SEQ-1-s) < outstanding, or when s = ACKD_SEQ.
  - Invalid s: ignored, dllp_err_o pulses.
  - Valid s ≠ ACKD_SEQ (forward progress): ACKD_SEQ ← s, replay_num ← 0, timer ← 0.
- NAK in NORMAL: apply the ACK rule first. If outstanding after the purge is > 0, enter REPLAY_RD with replay_ptr = new ACKD_SEQ+1 and increment replay_num.
- NAK in a replay state: apply the purge only; no new replay is scheduled.
- DLLP types other than 0x00/0x10 are ignored.
- Timer:
  - Counts in NORMAL while outstanding > 0 and holds during replay.
  - Cleared on forward progress, on replay start, and when outstanding reaches 0.
  - Reaching REPLAY_TIMEOUT-1 starts a replay exactly as a NAK does, without a purge.
- replay_num = 3 when a replay triggers: pulse retrain_o, set replay_num ← 0, and still perform the replay.
- Simultaneous events:
  - New accept + ACK in the same cycle: both take effect.
  - ACK forward progress + timer expiry: ACK wins, no replay.
  - NAK + timer expiry: a single replay, replay_num incremented once.
  - ACK purging entries already queued for replay: the replay still runs to NEXT_SEQ-1.

## Timing
- Reset values: new_ready_o, rb_wren_o, rb_rden_o, link_valid_o, link_sel_o, replay_active_o, retrain_o, dllp_err_o all 0. seq_o = 0, outstanding_o = 0, state = NORMAL.
- new_ready_o, rb_wren_o, link_valid_o and link_sel_o are combinational from state, the counters and the handshake inputs. All other status outputs are registered.
- DLLP effects are visible on the cycle after dllp_valid_i.
- A NAK at cycle t puts REPLAY_RD at t+1 and the first replayed link_valid_o at t+2.
- Replay throughput is 1 TLP per 2 cycles when link_ready_i stays high.
- Reset mid-replay returns to the reset state immediately; in-flight replay is discarded.

## Configuration
- URP_PCIE_REPLAY_STAT_EN defined: adds output replay_cnt_o [15:0], a saturating count of replays started (reset 0).
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Test plan
- Send 3 TLPs with link_ready_i=1 → seq_o 0,1,2, rb_waddr_o 0,1,2, outstanding_o = 3. Then ACK seq 2 → outstanding_o = 0, timer cleared.
- Fill 16 TLPs without an ACK → new_ready_o = 0 on the 17th. ACK seq 0 → new_ready_o = 1 the next cycle.
- 5 outstanding (seq 0..4), NAK seq 1 → ACKD_SEQ = 1. Replay reads addresses 2,3,4 with link_sel_o = 1 at t+2, t+4, t+6, then NORMAL.
- 2 outstanding, no DLLP for REPLAY_TIMEOUT cycles → replay of both. Repeat 4 times → retrain_o pulses once, replay_num = 0.
- NEXT_SEQ near 4095 across wrap (seq 4094, 4095, 0), ACK 0 → outstanding_o = 0. ACK seq 100 with an empty window → dllp_err_o pulse, no state change.
- Replay in progress + NAK + new_valid_i held: no second replay, new_ready_o = 0 until return to NORMAL.

Source files
------------

// File: rtl/urp_pcie_tx_replay_ctrl.sv
// urp_pcie_tx_replay_ctrl
// Sequence/replay controller for the PCIe TX data link layer retry path.
// Assigns sequence numbers to new TLPs, addresses the external retry buffer,
// consumes ACK/NAK DLLPs, runs the replay timer and REPLAY_NUM counter, and
// multiplexes the single link output between new TLPs and replayed TLPs.
// Optional feature: define URP_PCIE_REPLAY_STAT_EN to add replay_cnt_o, a
// saturating 16-bit count of replays started.
module urp_pcie_tx_replay_ctrl #(
    parameter int SEQ_W          = 12,
    parameter int BUF_LG2        = 4,
    parameter int REPLAY_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_valid_i,
    output logic               new_ready_o,
    output logic [SEQ_W-1:0]   seq_o,
    output logic               rb_wren_o,
    output logic [BUF_LG2-1:0] rb_waddr_o,
    output logic               rb_rden_o,
    output logic [BUF_LG2-1:0] rb_raddr_o,
    output logic               link_valid_o,
    output logic               link_sel_o,
    input  logic               link_ready_i,
    input  logic               dllp_valid_i,
    input  logic [31:0]        dllp_i,
    output logic               replay_active_o,
    output logic               retrain_o,
    output logic               dllp_err_o,
    output logic [BUF_LG2:0]   outstanding_o
`ifdef URP_PCIE_REPLAY_STAT_EN
    ,
    output logic [15:0]        replay_cnt_o
`endif
);

    localparam int TMR_W = (REPLAY_TIMEOUT > 2) ? $clog2(REPLAY_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TIMER_MAX = TMR_W'(REPLAY_TIMEOUT - 1);
    localparam logic [SEQ_W-1:0] SEQ_ONE   = SEQ_W'(1);
    localparam logic [SEQ_W-1:0] FULL_CNT  = SEQ_W'(2 ** BUF_LG2);

    typedef enum logic [1:0] {
        ST_NORMAL    = 2'd0,
        ST_REPLAY_RD = 2'd1,
        ST_REPLAY_TX = 2'd2
    } state_t;

    state_t             state;
    logic [SEQ_W-1:0]   next_seq;
    logic [SEQ_W-1:0]   ackd_seq;
    logic [SEQ_W-1:0]   replay_ptr;
    logic [TMR_W-1:0]   timer;
    logic [1:0]         replay_num;

    logic [SEQ_W-1:0]   outst;
    logic               full;
    logic [SEQ_W-1:0]   dllp_seq;
    logic               is_ack;
    logic               is_nak;
    logic [SEQ_W-1:0]   seq_dist;
    logic               seq_ok;
    logic               fwd;
    logic               seq_err;
    logic [SEQ_W-1:0]   next_seq_nxt;
    logic [SEQ_W-1:0]   ackd_nxt;
    logic [SEQ_W-1:0]   outst_nxt;
    logic               tmr_expire;
    logic               start_replay;
    logic [1:0]         rn_base;

    // Upper AckNak_Seq field bits beyond SEQ_W carry no information here
    logic unused_dllp_bits;
    assign unused_dllp_bits = ^dllp_i[23:SEQ_W];

    assign seq_o         = next_seq;
    assign rb_waddr_o    = next_seq[BUF_LG2-1:0];
    assign rb_raddr_o    = replay_ptr[BUF_LG2-1:0];
    assign outstanding_o = outst[BUF_LG2:0];

    // Handshake, DLLP window check and next-value decode for the counters
    always_comb begin
        outst        = next_seq - ackd_seq - SEQ_ONE;
        full         = (outst == FULL_CNT);

        new_ready_o  = (state == ST_NORMAL) && !full && link_ready_i;
        rb_wren_o    = new_valid_i && new_ready_o;
        link_valid_o = (state == ST_REPLAY_TX) || rb_wren_o;
        link_sel_o   = (state == ST_REPLAY_TX);

        dllp_seq     = dllp_i[SEQ_W-1:0];
        is_ack       = dllp_valid_i && (dllp_i[31:24] == 8'h00);
        is_nak       = dllp_valid_i && (dllp_i[31:24] == 8'h10);
        seq_dist     = next_seq - SEQ_ONE - dllp_seq;
        seq_ok       = (seq_dist < outst) || (dllp_seq == ackd_seq);
        fwd          = (is_ack || is_nak) && seq_ok && (dllp_seq != ackd_seq);
        seq_err      = (is_ack || is_nak) && !seq_ok;

        next_seq_nxt = rb_wren_o ? (next_seq + SEQ_ONE) : next_seq;
        ackd_nxt     = fwd ? dllp_seq : ackd_seq;
        outst_nxt    = next_seq_nxt - ackd_nxt - SEQ_ONE;
        rn_base      = fwd ? 2'd0 : replay_num;

        tmr_expire   = (state == ST_NORMAL) && (outst != '0) && (timer == TIMER_MAX);
        start_replay = (state == ST_NORMAL) && (outst_nxt != '0) &&
                       ((is_nak && seq_ok) || (tmr_expire && !fwd));
    end

    // Sequence bookkeeping, replay timer/counter and the replay state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_NORMAL;
            next_seq        <= '0;
            ackd_seq        <= '1;
            replay_ptr      <= '0;
            timer           <= '0;
            replay_num      <= 2'd0;
            rb_rden_o       <= 1'b0;
            replay_active_o <= 1'b0;
            retrain_o       <= 1'b0;
            dllp_err_o      <= 1'b0;
        end else begin
            next_seq   <= next_seq_nxt;
            ackd_seq   <= ackd_nxt;
            replay_num <= rn_base;
            retrain_o  <= 1'b0;
            dllp_err_o <= seq_err;

            if (fwd || (outst_nxt == '0)) begin
                timer <= '0;
            end

            case (state)
                ST_NORMAL: begin
                    if (start_replay) begin
                        state           <= ST_REPLAY_RD;
                        replay_ptr      <= ackd_nxt + SEQ_ONE;
                        timer           <= '0;
                        rb_rden_o       <= 1'b1;
                        replay_active_o <= 1'b1;
                        if (rn_base == 2'd3) begin
                            retrain_o  <= 1'b1;
                            replay_num <= 2'd0;
                        end else begin
                            replay_num <= rn_base + 2'd1;
                        end
                    end else if (!fwd && (outst_nxt != '0) && (outst != '0)) begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_REPLAY_RD: begin
                    state     <= ST_REPLAY_TX;
                    rb_rden_o <= 1'b0;
                end
                ST_REPLAY_TX: begin
                    if (link_ready_i) begin
                        if (replay_ptr == (next_seq - SEQ_ONE)) begin
                            state           <= ST_NORMAL;
                            timer           <= '0;
                            replay_active_o <= 1'b0;
                        end else begin
                            state      <= ST_REPLAY_RD;
                            replay_ptr <= replay_ptr + SEQ_ONE;
                            rb_rden_o  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state           <= ST_NORMAL;
                    rb_rden_o       <= 1'b0;
                    replay_active_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef URP_PCIE_REPLAY_STAT_EN
    logic [15:0] replay_cnt;

    // Saturating count of replays started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            replay_cnt <= '0;
        end else if (start_replay && (replay_cnt != 16'hFFFF)) begin
            replay_cnt <= replay_cnt + 16'd1;
        end
    end

    assign replay_cnt_o = replay_cnt;
`endif

endmodule

// File: tb/tb_urp_pcie_tx_replay_ctrl.sv
// tb_urp_pcie_tx_replay_ctrl
// Directed self-checking bench for urp_pcie_tx_replay_ctrl (default parameters).
module tb_urp_pcie_tx_replay_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_valid_i = 1'b0;
    logic        new_ready_o;
    logic [11:0] seq_o;
    logic        rb_wren_o;
    logic [3:0]  rb_waddr_o;
    logic        rb_rden_o;
    logic [3:0]  rb_raddr_o;
    logic        link_valid_o;
    logic        link_sel_o;
    logic        link_ready_i = 1'b0;
    logic        dllp_valid_i = 1'b0;
    logic [31:0] dllp_i = 32'h0;
    logic        replay_active_o;
    logic        retrain_o;
    logic        dllp_err_o;
    logic [4:0]  outstanding_o;
`ifdef URP_PCIE_REPLAY_STAT_EN
    logic [15:0] replay_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    int n;

    urp_pcie_tx_replay_ctrl #(
        .SEQ_W(12),
        .BUF_LG2(4),
        .REPLAY_TIMEOUT(1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .new_valid_i(new_valid_i),
        .new_ready_o(new_ready_o),
        .seq_o(seq_o),
        .rb_wren_o(rb_wren_o),
        .rb_waddr_o(rb_waddr_o),
        .rb_rden_o(rb_rden_o),
        .rb_raddr_o(rb_raddr_o),
        .link_valid_o(link_valid_o),
        .link_sel_o(link_sel_o),
        .link_ready_i(link_ready_i),
        .dllp_valid_i(dllp_valid_i),
        .dllp_i(dllp_i),
        .replay_active_o(replay_active_o),
        .retrain_o(retrain_o),
        .dllp_err_o(dllp_err_o),
        .outstanding_o(outstanding_o)
`ifdef URP_PCIE_REPLAY_STAT_EN
        ,
        .replay_cnt_o(replay_cnt_o)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [31:0] dllpWord(input logic [7:0] typ, input int seq);
        logic [31:0] w;
        w = {typ, 12'h000, 12'h000};
        w[11:0] = seq[11:0];
        return w;
    endfunction

    task automatic applyStimulus(input logic nv, input logic lr, input logic dv, input logic [31:0] d);
        new_valid_i  = nv;
        link_ready_i = lr;
        dllp_valid_i = dv;
        dllp_i       = d;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        stepClock();
        stepClock();
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset values
        doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_new_ready", new_ready_o, 0);
        checkOutput("rst_wren", rb_wren_o, 0);
        checkOutput("rst_rden", rb_rden_o, 0);
        checkOutput("rst_link_valid", link_valid_o, 0);
        checkOutput("rst_link_sel", link_sel_o, 0);
        checkOutput("rst_replay_active", replay_active_o, 0);
        checkOutput("rst_retrain", retrain_o, 0);
        checkOutput("rst_dllp_err", dllp_err_o, 0);
        checkOutput("rst_seq", seq_o, 0);
        checkOutput("rst_outstanding", outstanding_o, 0);
        stepClock();
        rst_n = 1'b1;

        // Three new TLPs, then ACK 2
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        checkOutput("t1_ready_blocked", new_ready_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("t1_seq", seq_o, i);
            checkOutput("t1_waddr", rb_waddr_o, i);
            checkOutput("t1_wren", rb_wren_o, 1);
            checkOutput("t1_link_valid", link_valid_o, 1);
            checkOutput("t1_link_sel", link_sel_o, 0);
            stepClock();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h00, 2));
        checkOutput("t1_outstanding3", outstanding_o, 3);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_outstanding0", outstanding_o, 0);
        checkOutput("t1_dllp_err", dllp_err_o, 0);

        // Fill the 16-entry window starting at seq 3
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        for (int i = 0; i < 16; i++) begin
            checkOutput("t2_fill_ready", new_ready_o, 1);
            stepClock();
        end
        checkOutput("t2_outstanding16", outstanding_o, 16);
        checkOutput("t2_full_ready", new_ready_o, 0);
        checkOutput("t2_full_wren", rb_wren_o, 0);
        checkOutput("t2_full_link_valid", link_valid_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, dllpWord(8'h00, 3));
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_ready_after_ack", new_ready_o, 1);
        checkOutput("t2_outstanding15", outstanding_o, 15);

        // NAK 1 with seq 0..4 outstanding replays 2,3,4
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h10, 1));
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t3_rd_rden", rb_rden_o, 1);
            checkOutput("t3_rd_raddr", rb_raddr_o, 2 + k);
            checkOutput("t3_rd_link_valid", link_valid_o, 0);
            checkOutput("t3_rd_new_ready", new_ready_o, 0);
            checkOutput("t3_active", replay_active_o, 1);
            stepClock();
            checkOutput("t3_tx_link_valid", link_valid_o, 1);
            checkOutput("t3_tx_link_sel", link_sel_o, 1);
            checkOutput("t3_tx_rden", rb_rden_o, 0);
            stepClock();
        end
        checkOutput("t3_done_active", replay_active_o, 0);
        checkOutput("t3_done_sel", link_sel_o, 0);
        checkOutput("t3_done_ready", new_ready_o, 1);
        checkOutput("t3_done_outstanding", outstanding_o, 3);

        // Replay timer expiry, five times in a row
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        stepClock();
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        for (int r = 1; r <= 5; r++) begin
            n = 0;
            while (rb_rden_o !== 1'b1 && n < 2000) begin
                stepClock();
                n++;
            end
            checkOutput("t4_timeout_cycles", n, (r == 1) ? 1023 : 1024);
            checkOutput("t4_retrain", retrain_o, (r == 4) ? 1 : 0);
            checkOutput("t4_raddr0", rb_raddr_o, 0);
            stepClock();
            checkOutput("t4_retrain_clear", retrain_o, 0);
            checkOutput("t4_tx0", link_sel_o, 1);
            stepClock();
            checkOutput("t4_raddr1", rb_raddr_o, 1);
            stepClock();
            checkOutput("t4_tx1", link_valid_o, 1);
            stepClock();
            checkOutput("t4_back_normal", replay_active_o, 0);
            checkOutput("t4_outstanding", outstanding_o, 2);
        end

        // Sequence wrap 4094, 4095, 0 and an out-of-window ACK
        doReset();
        for (int i = 0; i < 4094; i++) begin
            applyStimulus(1'b1, 1'b1, (i > 0), dllpWord(8'h00, i - 1));
            stepClock();
        end
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h00, 4093));
        checkOutput("t5_pre_outstanding", outstanding_o, 1);
        stepClock();
        checkOutput("t5_drained", outstanding_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        #1;
        checkOutput("t5_seq4094", seq_o, 4094);
        checkOutput("t5_waddr14", rb_waddr_o, 14);
        stepClock();
        checkOutput("t5_seq4095", seq_o, 4095);
        checkOutput("t5_waddr15", rb_waddr_o, 15);
        stepClock();
        checkOutput("t5_seq0", seq_o, 0);
        checkOutput("t5_waddr0", rb_waddr_o, 0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h00, 0));
        checkOutput("t5_wrap_outstanding3", outstanding_o, 3);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h00, 100));
        checkOutput("t5_ack0_outstanding", outstanding_o, 0);
        checkOutput("t5_ack0_no_err", dllp_err_o, 0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_err_pulse", dllp_err_o, 1);
        checkOutput("t5_err_outstanding", outstanding_o, 0);
        checkOutput("t5_err_seq", seq_o, 1);
        stepClock();
        checkOutput("t5_err_clear", dllp_err_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h20, 1));
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_other_type_outstanding", outstanding_o, 1);
        checkOutput("t5_other_type_err", dllp_err_o, 0);

        // NAK during replay with new_valid_i held
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) stepClock();
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h10, 1));
        stepClock();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_rd_raddr2", rb_raddr_o, 2);
        checkOutput("t6_rd_ready", new_ready_o, 0);
        checkOutput("t6_rd_wren", rb_wren_o, 0);
        stepClock();
        applyStimulus(1'b1, 1'b1, 1'b1, dllpWord(8'h10, 2));
        checkOutput("t6_tx_valid", link_valid_o, 1);
        checkOutput("t6_tx_ready", new_ready_o, 0);
        stepClock();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_rd_raddr3", rb_raddr_o, 3);
        checkOutput("t6_rd_rden3", rb_rden_o, 1);
        checkOutput("t6_purged_outstanding", outstanding_o, 2);
        checkOutput("t6_active", replay_active_o, 1);
        stepClock();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        stepClock();
        checkOutput("t6_hold_valid", link_valid_o, 1);
        checkOutput("t6_hold_sel", link_sel_o, 1);
        checkOutput("t6_hold_rden", rb_rden_o, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        stepClock();
        checkOutput("t6_rd_raddr4", rb_raddr_o, 4);
        stepClock();
        checkOutput("t6_tx4_sel", link_sel_o, 1);
        stepClock();
        checkOutput("t6_normal_active", replay_active_o, 0);
        checkOutput("t6_normal_ready", new_ready_o, 1);
        checkOutput("t6_normal_wren", rb_wren_o, 1);
        checkOutput("t6_normal_seq", seq_o, 5);
        stepClock();
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_no_second_rden", rb_rden_o, 0);
        checkOutput("t6_no_second_active", replay_active_o, 0);
        checkOutput("t6_final_outstanding", outstanding_o, 3);

        // Asynchronous reset in the middle of a replay
        applyStimulus(1'b0, 1'b1, 1'b1, dllpWord(8'h10, 3));
        stepClock();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t7_replay_started", replay_active_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_active", replay_active_o, 0);
        checkOutput("t7_rst_rden", rb_rden_o, 0);
        checkOutput("t7_rst_outstanding", outstanding_o, 0);
        checkOutput("t7_rst_seq", seq_o, 0);
        checkOutput("t7_rst_link_valid", link_valid_o, 0);
        stepClock();
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
